// File: rtl/rx_link_scheduler_pkg.sv
// Shared types and constants for the UART receive-path scheduler: FSM states,
// live link configuration, parity modes and divider baud-select codes.
package rx_link_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECV   = 2'b01,
    ST_SETTLE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } par_mode_t;

  // Baud-select codes understood by the frequency divider.
  typedef enum logic [1:0] {
    BD_SEL_0 = 2'b00,
    BD_SEL_1 = 2'b01,
    BD_SEL_2 = 2'b10,
    BD_SEL_3 = 2'b11
  } bd_sel_t;

  typedef struct packed {
    logic [1:0] bd_rate;
    logic       dnum;
    logic       snum;
    logic [1:0] par;
  } link_cfg_t;

  // Automatic re-step walks the divider codes in order and wraps.
  function automatic logic [1:0] next_bd(input logic [1:0] bd);
    case (bd)
      BD_SEL_0: return BD_SEL_1;
      BD_SEL_1: return BD_SEL_2;
      BD_SEL_2: return BD_SEL_3;
      default:  return BD_SEL_0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_link_scheduler_if.sv
// Bundle of receiver, host-configuration, byte-output and status signals
// around the scheduler; master is the scheduler, slave is its surroundings.
interface rx_link_scheduler_if;
  logic       rx_busy;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       parity_warning;
  logic       frame_warning;
  logic       cfg_req;
  logic [1:0] cfg_bd_rate;
  logic       cfg_dnum;
  logic       cfg_snum;
  logic [1:0] cfg_par;
  logic       cfg_ack;
  logic [1:0] bd_rate;
  logic       dnum;
  logic       snum;
  logic [1:0] par;
  logic       rx_en;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       overrun;
  logic [7:0] err_count;
  logic       relock;
  logic       link_lost;

  modport master (
    input  rx_busy, rx_done, rx_data, parity_warning, frame_warning,
    input  cfg_req, cfg_bd_rate, cfg_dnum, cfg_snum, cfg_par, byte_ready,
    output cfg_ack, bd_rate, dnum, snum, par, rx_en,
    output byte_data, byte_valid, overrun, err_count, relock, link_lost
  );

  modport slave (
    output rx_busy, rx_done, rx_data, parity_warning, frame_warning,
    output cfg_req, cfg_bd_rate, cfg_dnum, cfg_snum, cfg_par, byte_ready,
    input  cfg_ack, bd_rate, dnum, snum, par, rx_en,
    input  byte_data, byte_valid, overrun, err_count, relock, link_lost
  );
endinterface

// File: rtl/rx_link_scheduler_skid.sv
// Single-entry output register for qualified bytes: valid/ready handshake,
// same-cycle drain and reload, sticky overrun when a byte cannot be held.
module rx_byte_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       overrun
);

  logic accept;

  assign accept = load && (!valid || ready);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      // NOTE: the data register is reset too, so byte_data is defined from reset.
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (load && !accept) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/rx_link_scheduler.sv
// UART receive-path scheduler: owns live link configuration, qualifies frames,
// forwards good bytes, counts errors, re-steps baud and watches for link loss.
module rx_link_scheduler
  import rx_link_scheduler_pkg::*;
#(
  parameter int         ERR_LIMIT   = 4,
  parameter int         SETTLE_CYC  = 16,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         CNT_W       = 20,
  parameter logic [1:0] DEF_BD_RATE = BD_SEL_0
) (
  input  logic                 clk,
  input  logic                 rst,
  rx_link_scheduler_if.master  lnk
);

  localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       ERR_LAST = 4'(ERR_LIMIT - 1);

  state_t           state_q, state_d;
  link_cfg_t        cfg_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic             boot_q, host_q, rx_en_q, ack_q, relock_q, lost_q;
  logic [7:0]       err_q;
  logic [3:0]       consec_q;
  logic [CNT_W-1:0] to_cnt_q;

  logic frame_evt, frame_bad, good_frame, bad_frame, restep;
  logic settle_last, boot_go, host_load, settle_enter;

  // Frames completing while the link settles belong to the old configuration.
  assign frame_evt   = lnk.rx_done && (state_q != ST_SETTLE);
  assign frame_bad   = lnk.parity_warning || lnk.frame_warning;
  assign good_frame  = frame_evt && !frame_bad;
  assign bad_frame   = frame_evt && frame_bad;
  assign restep      = bad_frame && (consec_q == ERR_LAST);
  assign settle_last = (state_q == ST_SETTLE) && (settle_cnt_q == SET_LAST);

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_d   = state_q;
    boot_go   = 1'b0;
    host_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (restep) begin
          state_d = ST_SETTLE;
        end else if (!lnk.rx_done) begin
          if (boot_q) begin
            boot_go = 1'b1;
            state_d = ST_SETTLE;
          end else if (lnk.rx_busy) begin
            state_d = ST_RECV;
          end else if (lnk.cfg_req && !ack_q) begin
            // ack_q guards against re-loading a request the host has not yet dropped
            host_load = 1'b1;
            state_d   = ST_SETTLE;
          end
        end
      end
      ST_RECV: begin
        if (restep)           state_d = ST_SETTLE;
        else if (lnk.rx_done) state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (settle_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign settle_enter = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '{bd_rate: DEF_BD_RATE, dnum: 1'b0, snum: 1'b0, par: PAR_NONE};
      settle_cnt_q <= '0;
      boot_q       <= 1'b1;
      host_q       <= 1'b0;
      rx_en_q      <= 1'b0;
      ack_q        <= 1'b0;
      relock_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= settle_last && host_q;
      relock_q <= restep;
      if (boot_go) boot_q <= 1'b0;
      if (host_load) begin
        cfg_q <= '{bd_rate: lnk.cfg_bd_rate, dnum: lnk.cfg_dnum,
                   snum: lnk.cfg_snum, par: lnk.cfg_par};
      end else if (restep) begin
        cfg_q.bd_rate <= next_bd(cfg_q.bd_rate);
      end
      if (settle_enter) begin
        settle_cnt_q <= '0;
        host_q       <= host_load;
        rx_en_q      <= 1'b0;
      end else if (state_q == ST_SETTLE) begin
        settle_cnt_q <= settle_cnt_q + SET_W'(1);
        if (settle_last) rx_en_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q    <= '0;
      consec_q <= '0;
    end else if (good_frame || restep) begin
      consec_q <= '0;
      if (restep) err_q <= sat_inc8(err_q);
    end else if (bad_frame) begin
      consec_q <= consec_q + 4'd1;
      err_q    <= sat_inc8(err_q);
    end
  end

  // The timeout counter parks at its last value once the link is declared lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      lost_q   <= 1'b0;
    end else if (settle_enter) begin
      to_cnt_q <= '0;
    end else if (state_q != ST_SETTLE) begin
      if (good_frame) begin
        to_cnt_q <= '0;
        lost_q   <= 1'b0;
      end else if (to_cnt_q == TO_LAST) begin
        lost_q <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + CNT_W'(1);
        if ((to_cnt_q + CNT_W'(1)) == TO_LAST) lost_q <= 1'b1;
      end
    end
  end

  rx_byte_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (good_frame),
    .load_data (lnk.rx_data),
    .ready     (lnk.byte_ready),
    .valid     (lnk.byte_valid),
    .data      (lnk.byte_data),
    .overrun   (lnk.overrun)
  );

  assign lnk.bd_rate   = cfg_q.bd_rate;
  assign lnk.dnum      = cfg_q.dnum;
  assign lnk.snum      = cfg_q.snum;
  assign lnk.par       = cfg_q.par;
  assign lnk.rx_en     = rx_en_q;
  assign lnk.cfg_ack   = ack_q;
  assign lnk.relock    = relock_q;
  assign lnk.err_count = err_q;
  assign lnk.link_lost = lost_q;

endmodule

// File: tb/tb_rx_link_scheduler.sv
// Self-checking bench for rx_link_scheduler: directed scenarios plus random
// receiver/host/controller traffic, compared every cycle against a reference model.
module tb_rx_link_scheduler;

  localparam int         ERR_LIMIT   = 4;
  localparam int         SETTLE_CYC  = 16;
  localparam int         TIMEOUT_CYC = 100;
  localparam logic [1:0] DEF_BD      = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rx_link_scheduler_if lnk ();

  rx_link_scheduler #(
    .ERR_LIMIT   (ERR_LIMIT),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (20),
    .DEF_BD_RATE (DEF_BD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lnk (lnk)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: settling is a countdown, a frame in flight is a flag,
  // the output register is a single held byte.
  int         m_settle_left, m_consec, m_err, m_tcnt;
  bit         m_in_frame, m_boot, m_host, m_rx_en, m_ack, m_relock;
  bit         m_valid, m_over, m_lost, m_dnum, m_snum;
  logic [1:0] m_bd, m_par;
  logic [7:0] m_data;

  task automatic model_reset();
    m_settle_left = 0; m_consec = 0; m_err = 0; m_tcnt = 0;
    m_in_frame = 0; m_boot = 1; m_host = 0; m_rx_en = 0; m_ack = 0; m_relock = 0;
    m_valid = 0; m_over = 0; m_lost = 0; m_dnum = 0; m_snum = 0;
    m_bd = DEF_BD; m_par = 2'b00; m_data = 8'h00;
  endtask

  task automatic model_edge();
    bit in_set, prev_ack, good, enter, host_ld;
    in_set   = (m_settle_left > 0);
    prev_ack = m_ack;
    good = 0; enter = 0; host_ld = 0;
    m_ack = 0; m_relock = 0;
    if (in_set) begin
      m_settle_left--;
      if (m_settle_left == 0) begin
        m_rx_en = 1;
        m_ack   = m_host;
      end
    end else if (lnk.rx_done) begin
      m_in_frame = 0;
      if (!lnk.parity_warning && !lnk.frame_warning) begin
        good = 1;
        m_consec = 0;
      end else begin
        if (m_err < 255) m_err++;
        m_consec++;
        if (m_consec == ERR_LIMIT) begin
          m_consec = 0;
          m_bd     = m_bd + 2'd1;
          m_relock = 1;
          enter    = 1;
        end
      end
    end else if (!m_in_frame) begin
      if (m_boot) begin
        m_boot = 0;
        enter  = 1;
      end else if (lnk.rx_busy) begin
        m_in_frame = 1;
      end else if (lnk.cfg_req && !prev_ack) begin
        m_bd = lnk.cfg_bd_rate; m_dnum = lnk.cfg_dnum;
        m_snum = lnk.cfg_snum;  m_par = lnk.cfg_par;
        host_ld = 1;
        enter   = 1;
      end
    end
    if (enter) begin
      m_settle_left = SETTLE_CYC;
      m_rx_en = 0;
      m_host  = host_ld;
      m_tcnt  = 0;
    end else if (!in_set) begin
      if (good) begin
        m_tcnt = 0;
        m_lost = 0;
      end else if (m_tcnt < TIMEOUT_CYC - 1) begin
        m_tcnt++;
        if (m_tcnt == TIMEOUT_CYC - 1) m_lost = 1;
      end else begin
        m_lost = 1;
      end
    end
    if (good && (!m_valid || lnk.byte_ready)) begin
      m_valid = 1;
      m_data  = lnk.rx_data;
    end else begin
      if (good) m_over = 1;
      if (m_valid && lnk.byte_ready) m_valid = 0;
    end
  endtask

  task automatic compare();
    logic [11:0] got_v, exp_v;
    got_v = {lnk.rx_en, lnk.bd_rate, lnk.dnum, lnk.snum, lnk.par, lnk.cfg_ack,
             lnk.relock, lnk.byte_valid, lnk.overrun, lnk.link_lost};
    exp_v = {m_rx_en, m_bd, m_dnum, m_snum, m_par, m_ack,
             m_relock, m_valid, m_over, m_lost};
    check("ctrl{en,bd,d,s,par,ack,rl,v,ov,lost}", 32'(got_v), 32'(exp_v));
    check("byte_data", 32'(lnk.byte_data), 32'(m_data));
    check("err_count", 32'(lnk.err_count), 32'(m_err[7:0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_inputs();
    lnk.rx_busy = 0; lnk.rx_done = 0; lnk.rx_data = 8'h00;
    lnk.parity_warning = 0; lnk.frame_warning = 0;
    lnk.cfg_req = 0; lnk.cfg_bd_rate = 2'b00; lnk.cfg_dnum = 0;
    lnk.cfg_snum = 0; lnk.cfg_par = 2'b00; lnk.byte_ready = 0;
  endtask

  task automatic wait_rx_en();
    for (int i = 0; i < 64 && !m_rx_en; i++) step();
    if (!m_rx_en) check("rx_en_wait", 32'(lnk.rx_en), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pw, input logic fw,
                            input int busy_n);
    lnk.rx_busy = 1;
    repeat (busy_n) step();
    lnk.rx_busy = 0; lnk.rx_done = 1; lnk.rx_data = d;
    lnk.parity_warning = pw; lnk.frame_warning = fw;
    step();
    lnk.rx_done = 0; lnk.parity_warning = 0; lnk.frame_warning = 0;
  endtask

  task automatic do_cfg(input logic [1:0] bd, input logic d, input logic s,
                        input logic [1:0] p);
    lnk.cfg_req = 1; lnk.cfg_bd_rate = bd; lnk.cfg_dnum = d;
    lnk.cfg_snum = s; lnk.cfg_par = p;
    for (int i = 0; i < 200 && !m_ack; i++) step();
    if (!m_ack) check("cfg_ack_wait", 32'(lnk.cfg_ack), 32'd1);
    lnk.cfg_req = 0;
  endtask

  int r_busy_left = 0;
  bit r_pending   = 0;

  task automatic drive_random();
    lnk.byte_ready = ($urandom_range(0, 3) != 0);
    lnk.rx_done = 0; lnk.parity_warning = 0; lnk.frame_warning = 0;
    if (r_busy_left > 1) begin
      r_busy_left--;
    end else if (r_busy_left == 1) begin
      r_busy_left = 0;
      lnk.rx_busy = 0; lnk.rx_done = 1; lnk.rx_data = 8'($urandom);
      lnk.parity_warning = ($urandom_range(0, 2) == 0);
      lnk.frame_warning  = ($urandom_range(0, 2) == 0);
    end else if (m_settle_left > 0 && $urandom_range(0, 15) == 0) begin
      lnk.rx_done = 1; lnk.rx_data = 8'($urandom);
      lnk.parity_warning = ($urandom_range(0, 1) == 0);
    end else if (m_rx_en && $urandom_range(0, 3) == 0) begin
      r_busy_left = $urandom_range(1, 5);
      lnk.rx_busy = 1;
    end
    if (r_pending && m_ack) begin
      lnk.cfg_req = 0;
      r_pending   = 0;
    end else if (!r_pending && $urandom_range(0, 39) == 0) begin
      lnk.cfg_req = 1; r_pending = 1;
      lnk.cfg_bd_rate = 2'($urandom); lnk.cfg_dnum = 1'($urandom);
      lnk.cfg_snum = 1'($urandom);    lnk.cfg_par = 2'($urandom);
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    rst = 1;

    // Boot settle: rx_en held low, no ack.
    repeat (SETTLE_CYC + 4) step();
    check("bd_after_reset", 32'(lnk.bd_rate), 32'(DEF_BD));

    // Single good byte with the controller ready.
    lnk.byte_ready = 1;
    send_frame(8'hA5, 0, 0, 3);
    check("a5_valid", 32'(lnk.byte_valid), 32'd1);
    check("a5_data", 32'(lnk.byte_data), 32'hA5);
    repeat (2) step();
    check("a5_err", 32'(lnk.err_count), 32'd0);

    // Back-pressure: second byte is dropped and overrun sticks.
    lnk.byte_ready = 0;
    send_frame(8'h11, 0, 0, 2);
    send_frame(8'h22, 0, 0, 2);
    step();
    check("bp_data", 32'(lnk.byte_data), 32'h11);
    check("bp_overrun", 32'(lnk.overrun), 32'd1);
    lnk.byte_ready = 1;
    repeat (2) step();

    // Four bad frames at bd_rate 11 wrap the baud select to 00.
    do_cfg(2'b11, 0, 0, 2'b00);
    for (int k = 0; k < ERR_LIMIT; k++) begin
      wait_rx_en();
      send_frame(8'(k), 1, 0, 2);
    end
    check("restep_relock", 32'(lnk.relock), 32'd1);
    check("restep_bd", 32'(lnk.bd_rate), 32'd0);
    check("restep_err", 32'(lnk.err_count), 32'd4);
    wait_rx_en();

    // Configuration requested mid-frame waits for the frame to finish.
    lnk.rx_busy = 1;
    repeat (2) step();
    lnk.cfg_req = 1; lnk.cfg_bd_rate = 2'b10; lnk.cfg_dnum = 0;
    lnk.cfg_snum = 0; lnk.cfg_par = 2'b01;
    repeat (5) step();
    check("midframe_bd_hold", 32'(lnk.bd_rate), 32'd0);
    check("midframe_par_hold", 32'(lnk.par), 32'd0);
    lnk.rx_busy = 0; lnk.rx_done = 1; lnk.rx_data = 8'h3C;
    step();
    lnk.rx_done = 0;
    for (int i = 0; i < 200 && !m_ack; i++) step();
    check("cfg_ack_seen", 32'(lnk.cfg_ack), 32'd1);
    check("cfg_bd_live", 32'(lnk.bd_rate), 32'b10);
    check("cfg_par_live", 32'(lnk.par), 32'b01);
    lnk.cfg_req = 0;

    // Silence long enough to lose the link, then a good frame recovers it.
    repeat (TIMEOUT_CYC + 10) step();
    check("link_lost_set", 32'(lnk.link_lost), 32'd1);
    send_frame(8'h5A, 0, 0, 2);
    check("link_lost_clear", 32'(lnk.link_lost), 32'd0);

    // Random traffic from receiver, host and controller.
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end
    clear_inputs();
    lnk.byte_ready = 1;
    step();

    // Error counter saturation.
    for (int k = 0; k < 260; k++) begin
      wait_rx_en();
      send_frame(8'($urandom), 1, 0, 1);
    end
    check("err_saturate", 32'(lnk.err_count), 32'd255);

    // Asynchronous reset in the middle of a frame.
    wait_rx_en();
    lnk.rx_busy = 1;
    repeat (2) step();
    #2 rst = 0;
    #1;
    check("rst_ctrl", 32'({lnk.rx_en, lnk.bd_rate, lnk.dnum, lnk.snum, lnk.par,
                           lnk.cfg_ack, lnk.relock, lnk.byte_valid, lnk.overrun,
                           lnk.link_lost}), 32'({1'b0, DEF_BD, 9'b0}));
    check("rst_data", 32'(lnk.byte_data), 32'd0);
    check("rst_err", 32'(lnk.err_count), 32'd0);
    clear_inputs();
    model_reset();
    @(negedge clk);
    compare();
    rst = 1;
    repeat (SETTLE_CYC + 4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_link_scheduler.md
Name: rx_link_scheduler

Overview:
Sequences and configures the UART receive path: frequency divider, receiver and temperature controller. It owns the live link configuration (baud select, data/stop bit count, parity mode) and changes it only between frames. It qualifies each received byte against the parity and frame warnings and hands good bytes to the temperature controller over a valid/ready handshake. It tracks errors and re-steps the baud select automatically after repeated bad frames.

Parameters:
ERR_LIMIT, 4, consecutive errored frames that trigger an automatic baud re-step (1..15)
SETTLE_CYC, 16, clk cycles rx_en is held low after any configuration change (>=1)
TIMEOUT_CYC, 1000000, clk cycles without a good frame before link_lost asserts
CNT_W, 20, width of the timeout counter (2^CNT_W > TIMEOUT_CYC)
DEF_BD_RATE, 2'b00, bd_rate value loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_busy  in  1  receiver is mid-frame (start bit seen, stop not done)
rx_done  in  1  one-cycle strobe: frame complete; rx_data and warnings valid this cycle
rx_data  in  8  received byte
parity_warning  in  1  parity error on the completing frame
frame_warning  in  1  stop-bit error on the completing frame
cfg_req  in  1  host requests a new configuration; held until cfg_ack
cfg_bd_rate  in  2  requested baud select
cfg_dnum  in  1  requested data-bit mode
cfg_snum  in  1  requested stop-bit mode
cfg_par  in  2  requested parity mode
cfg_ack  out  1  one-cycle pulse: requested configuration now live
bd_rate  out  2  live baud select to divider
dnum  out  1  live data-bit mode
snum  out  1  live stop-bit mode
par  out  2  live parity mode
rx_en  out  1  receiver enable
byte_data  out  8  qualified byte to controller
byte_valid  out  1  byte_data valid
byte_ready  in  1  controller accepts byte
overrun  out  1  sticky: good byte dropped because output register full
err_count  out  8  total errored frames, saturating at 255
relock  out  1  one-cycle pulse on automatic baud re-step
link_lost  out  1  no good frame for TIMEOUT_CYC cycles

Behaviour:
- Reset (rst=0, takes effect immediately, mid-frame included):
  - state=IDLE; bd_rate=DEF_BD_RATE; dnum=0; snum=0; par=2'b00; rx_en=0.
  - byte_valid=0, byte_data=0; overrun=0; err_count=0; consecutive-error counter=0.
  - cfg_ack=0; relock=0; link_lost=0; timeout counter=0.
  - The first cycle after reset release enters SETTLE, so rx_en=1 after SETTLE_CYC cycles.
- FSM states: IDLE, RECV, SETTLE.
  - IDLE: rx_busy=1 -> RECV. cfg_req=1 with rx_busy=0 -> load cfg_* into live registers and go to SETTLE.
  - RECV: leave to IDLE on the rx_done cycle. cfg_req is ignored while in RECV.
  - SETTLE: rx_en=0 and a counter runs SETTLE_CYC cycles. On the last cycle set rx_en=1 and go to IDLE. cfg_ack pulses on that last cycle only if the entry was host-initiated.
- Frame qualification, on the rx_done cycle (any state except SETTLE; rx_done in SETTLE is ignored):
  - Good frame (both warnings 0): consecutive-error counter=0; timeout counter=0; link_lost=0.
    - Output register empty, or byte_ready=1 in the same cycle: byte_data<=rx_data and byte_valid=1 next cycle.
    - Otherwise: byte dropped and overrun<=1. overrun is cleared only by reset.
  - Errored frame (either warning 1): byte discarded; err_count+1, saturating at 255; consecutive-error counter+1.
    - When the consecutive counter reaches ERR_LIMIT: bd_rate<=bd_rate+1 (mod 4, wraps 3->0); relock pulses one cycle; consecutive counter=0; enter SETTLE (no cfg_ack).
- Output handshake: byte_valid clears the cycle after byte_valid&&byte_ready, unless a new good byte loads in that same cycle. byte_data holds stable while byte_valid=1 and byte_ready=0.
- Simultaneous events:
  - rx_done and cfg_req in the same cycle: the frame is processed first; cfg is applied on a later IDLE cycle.
  - Auto re-step and a pending cfg_req: the re-step wins; the host value is applied after SETTLE, and its cfg_ack follows that second SETTLE.
- Timeout: counter increments every cycle outside SETTLE and clears on a good frame or on SETTLE entry. At TIMEOUT_CYC-1 the counter stops and link_lost=1.
- Latency: good byte on rx_done at cycle N gives byte_valid=1 at N+1.

Decomposition:
- Shared package: state encoding (IDLE/RECV/SETTLE), the parity-mode constants (NONE, ODD, EVEN), and the bd_rate encodings used by the frequency divider.
- One natural sub-module: rx_byte_skid, the single-entry output register with valid/ready, overrun flag and same-cycle load/drain.

Test Plan:
- Reset release -> rx_en=0 for 16 cycles, then 1; bd_rate=00, all flags 0, cfg_ack never pulses.
- Good frame rx_data=8'hA5, byte_ready=1 -> byte_valid=1 with byte_data=A5 one cycle later, then 0; err_count=0.
- Two good frames 8'h11, 8'h22 with byte_ready=0 -> byte_data stays 11; overrun=1; 22 is never presented.
- Four frames with parity_warning=1 at bd_rate=11 -> err_count=4; relock pulses once; bd_rate=00; rx_en low 16 cycles.
- cfg_req with bd_rate=10, par=01, raised while rx_busy=1 -> no change until the rx_done of the current frame; then bd_rate/par update, SETTLE runs, and cfg_ack pulses once 16 cycles later.
- TIMEOUT_CYC=100 with no frames -> link_lost=1 from cycle 99; a good frame clears it. rst pulsed low mid-frame -> all outputs return to reset values the same cycle.
